// File: rtl/axi_master_bridge.sv
// Single-outstanding AXI4 master bridge.
// Core read bursts and single-beat writes become AXI4 transactions; each beat or write completion comes back as a one-cycle response.
module axi_master_bridge #(
    parameter logic [3:0] AXI_ID  = 4'd0,
    parameter logic [7:0] MAX_LEN = 8'd7
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_len,
    input  logic [2:0]  req_size,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        resp_valid,
    output logic [63:0] resp_data,
    output logic        resp_last,
    output logic        resp_err,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        WR_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        over_q, over_d;
    logic        arvalid_q, arvalid_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        rvld_q, rvld_d;
    logic [63:0] rdat_q, rdat_d;
    logic        rlst_q, rlst_d;
    logic        rerr_q, rerr_d;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            cnt_q     <= '0;
            over_q    <= 1'b0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rvld_q    <= 1'b0;
            rdat_q    <= '0;
            rlst_q    <= 1'b0;
            rerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            cnt_q     <= cnt_d;
            over_q    <= over_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            rvld_q    <= rvld_d;
            rdat_q    <= rdat_d;
            rlst_q    <= rlst_d;
            rerr_q    <= rerr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        cnt_d     = cnt_q;
        over_d    = over_q;
        arvalid_d = arvalid_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        rvld_d    = 1'b0;
        rdat_d    = '0;
        rlst_d    = 1'b0;
        rerr_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    len_d   = (req_len > MAX_LEN) ? MAX_LEN : req_len;
                    size_d  = req_size;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    if (req_wen) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    cnt_d     = '0;
                    over_d    = 1'b0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid) begin
                    rvld_d = 1'b1;
                    rdat_d = rdata;
                    rlst_d = rlast;
                    // once the burst overran its length every later beat is suspect
                    rerr_d = (rresp != 2'b00) || (rid != AXI_ID) || over_q
                           || (rlast != (cnt_q == len_q));
                    cnt_d  = cnt_q + 8'd1;
                    if ((cnt_q == len_q) && !rlast) begin
                        over_d = 1'b1;
                    end
                    if (rlast) begin
                        state_d = IDLE;
                    end
                end
            end
            WR: begin
                if (awready) begin
                    awvalid_d = 1'b0;
                end
                if (wready) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    rvld_d  = 1'b1;
                    rlst_d  = 1'b1;
                    rerr_d  = (bresp != 2'b00) || (bid != AXI_ID);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = rvld_q;
    assign resp_data  = rdat_q;
    assign resp_last  = rlst_q;
    assign resp_err   = rerr_q;

    assign araddr  = addr_q;
    assign arid    = AXI_ID;
    assign arlen   = len_q;
    assign arsize  = size_q;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = arvalid_q;
    assign rready  = (state_q == RD_DATA);

    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = size_q;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = awvalid_q;

    assign wid    = AXI_ID;
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;
    assign wlast  = wvalid_q;
    assign wvalid = wvalid_q;
    assign bready = (state_q == WR_RESP);

endmodule

// File: doc/axi_master_bridge.md
Name: axi_master_bridge

Overview:
- Single-outstanding AXI4 master: turns simple core memory requests (IFU line fills, LSU loads/stores) into AXI4 read bursts or single-beat writes.
- Returns read beats and write completions on a simple response port.
- Sits between core/cache request logic and the AXI4 slave side (sim_sram or crossbar).

Parameters:
- AXI_ID, 4'd0, constant ID driven on arid/awid/wid; also the expected rid/bid.
- MAX_LEN, 8'd7, largest accepted req_len; larger values are clamped to MAX_LEN.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  bridge idle, request accepted when req_valid && req_ready
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_len  in  8  read beats minus 1; ignored for writes (always 1 beat)
- req_size  in  3  log2 bytes per beat
- req_wdata  in  64  write data
- req_wstrb  in  8  write byte strobes
- resp_valid  out  1  one-cycle pulse per read beat or write completion
- resp_data  out  64  read data (0 for write completion)
- resp_last  out  1  final response of the transaction
- resp_err  out  1  response error (see Behaviour)
- AXI master signals: araddr[32], arid[4], arlen[8], arsize[3], arburst[2], arlock[2], arcache[4], arprot[3], arvalid, arready(in); rid(in)[4], rdata(in)[64], rresp(in)[2], rlast(in), rvalid(in), rready; awid[4], awaddr[32], awlen[8], awsize[3], awburst[2], awlock[2], awcache[4], awprot[3], awvalid, awready(in); wid[4], wdata[64], wstrb[8], wlast, wvalid, wready(in); bid(in)[4], bresp(in)[2], bvalid(in), bready

Behaviour:
- Constants: arburst = awburst = 2'b01 (INCR); arlock/awlock/arcache/awcache/arprot/awprot = 0; awlen = 0; wlast = wvalid; IDs = AXI_ID.
- Reset (aresetn low at posedge): state IDLE. Outputs: req_ready = 1, all valid/ready outputs 0, resp_* = 0, address/len/size/data registers = 0.
- Reset mid-transaction: state forced to IDLE with outputs at reset values. Any in-flight AXI transaction is dropped, with no response.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP. req_ready = 1 only in IDLE.
- IDLE: on a request handshake at cycle N, latch addr/len(clamped)/size/wdata/wstrb.
  - Read: go to RD_ADDR; arvalid = 1 from N+1.
  - Write: go to WR; awvalid = 1 and wvalid = 1 from N+1.
- RD_ADDR: hold arvalid and AR payload stable until arready. Then arvalid = 0, clear beat counter, go to RD_DATA.
- RD_DATA: rready = 1. On each rvalid && rready beat:
  - Next cycle: resp_valid = 1, resp_data = rdata, resp_last = rlast.
  - resp_err = (rresp != 0) || (rid != AXI_ID) || (rlast != (cnt == len)).
  - cnt increments.
  - Beat with rlast = 1: go to IDLE (req_ready = 1 the cycle after the beat).
  - cnt == len without rlast: flag that beat as an error, stay until rlast arrives; later beats also carry resp_err = 1.
- WR: awvalid and wvalid drop independently after their own handshakes; either may complete first or both in the same cycle. Once both are done, go to WR_RESP.
- WR_RESP: bready = 1. On bvalid, next cycle resp_valid = 1, resp_last = 1, resp_data = 0, resp_err = (bresp != 0) || (bid != AXI_ID); go to IDLE.
- resp_valid is a single-cycle pulse; the consumer cannot backpressure.
- Unsolicited handshakes are ignored: rvalid outside RD_DATA and bvalid outside WR_RESP (rready/bready are 0 there).
- No new request is accepted until the previous response issues; no AR/AW overlap.

Test Plan:
- Single read: req addr 0x80000000, len 0, size 3; slave arready after 2 cycles, rdata 0x1122334455667788 with rlast → one resp pulse, data matches, last = 1, err = 0, req_ready back high the next cycle.
- Burst read: len 3 at 0x80000100; slave returns 4 beats with 1-cycle gaps, rlast on the 4th → 4 pulses in order, last only on the 4th; araddr = 0x80000100, arlen = 3, arburst = 1.
- Write with wready before awready: addr 0x80000008, wdata 0xDEADBEEF, wstrb 0x0F; wready at N+1, awready at N+3, then bvalid → wvalid drops at N+2, awvalid at N+4, single resp with last = 1, err = 0.
- Error paths: rresp = 2 on a single read → err = 1; bresp = 3 → err = 1; rlast on beat 2 of a len-3 burst → err = 1 on that beat and the FSM returns to IDLE.
- Reset during RD_DATA after 1 of 4 beats → all outputs at reset values next cycle; a new read after reset completes normally.
- req_len = 20 with MAX_LEN = 7 → arlen = 7, exactly 8 response beats.
